// File: rtl/uart_pkg.sv
// Shared definitions for the parity-capable UART receiver: FSM state
// encoding, frame geometry and the layout of one received-byte FIFO entry.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int ENTRY_W   = 10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_CLEANUP   = 3'd5,
    ST_WAIT_HIGH = 3'd6
  } rx_state_e;

  // One FIFO entry: error flags on top, data byte underneath.
  typedef struct packed {
    logic                 frame_err;
    logic                 parity_err;
    logic [DATA_BITS-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO for received entries. Pointers carry one extra wrap bit
// so full and empty are told apart by their MSBs. A push into a full FIFO
// is still accepted when a pop happens in the same cycle; otherwise it is
// dropped and reported on overflow_o for one cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             empty, full, do_pop, do_push;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = !empty && ready_i;
  assign do_push = push_i && (!full || do_pop);

  assign overflow_o = push_i && full && !do_pop;
  assign valid_o    = !empty;
  // Head is forced to zero while empty so the outputs read 0 out of reset.
  assign data_o     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  // Pointer registers; they wrap modulo 2*DEPTH by natural overflow.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write port.
  // NOTE: the array has no reset; empty-gating of data_o hides stale contents.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/uart_rx_parity.sv
// UART receiver with optional even parity, frame-error detection, break
// handling and a small show-ahead output FIFO with sticky overrun flag.
// CLKS_PER_BIT must be at least 4; FIFO_DEPTH a power of two, at least 2.
module uart_rx_parity
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter bit PARITY_EN    = 1'b1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  input  logic       i_Rx_Ready,
  input  logic       i_Clr_Overrun,
  output logic       o_Rx_Valid,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Parity_Err,
  output logic       o_Frame_Err,
  output logic       o_Overrun,
  output logic       o_Rx_Active
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rx_meta_q, rx_sync_q;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 active_q, active_d;
  logic                 overrun_q, overrun_d;
  logic                 push;
  logic                 bit_end;
  logic                 fifo_drop;
  rx_entry_t            push_entry;
  rx_entry_t            head;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign bit_end = (cnt_q == CNT_LAST);

  // Next-state and datapath decode for the frame FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latches.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    push    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_sync_q) begin
          cnt_d   = '0;
          idx_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          state_d = ST_START;
        end
      end

      ST_START: begin
        // Re-check the line half a bit in; a high line means a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_sync_q;
          if (idx_q == IDX_LAST) begin
            state_d = PARITY_EN ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          perr_d  = (^shift_q) ^ rx_sync_q;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            state_d = ST_CLEANUP;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WAIT_HIGH: begin
        // Hold off through a break so the low line is not taken as a start.
        if (rx_sync_q) begin
          state_d = ST_CLEANUP;
        end
      end

      ST_CLEANUP: begin
        push    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Active flag trails the FSM by one cycle, covering START through CLEANUP.
  assign active_d = (state_q != ST_IDLE);

  // Sticky overrun: a drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    overrun_d = overrun_q;
    if (fifo_drop) begin
      overrun_d = 1'b1;
    end else if (i_Clr_Overrun) begin
      overrun_d = 1'b0;
    end
  end

  // FSM, counters, shift register and status flags.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      active_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      active_q  <= active_d;
      overrun_q <= overrun_d;
    end
  end

  assign push_entry.frame_err  = ferr_q;
  assign push_entry.parity_err = perr_q;
  assign push_entry.data       = shift_q;

  uart_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (i_Clock),
    .rst_ni     (i_Rst_n),
    .push_i     (push),
    .data_i     (push_entry),
    .ready_i    (i_Rx_Ready),
    .valid_o    (o_Rx_Valid),
    .data_o     (head),
    .overflow_o (fifo_drop)
  );

  assign o_Rx_Byte    = head.data;
  assign o_Parity_Err = PARITY_EN && head.parity_err;
  assign o_Frame_Err  = head.frame_err;
  assign o_Overrun    = overrun_q;
  assign o_Rx_Active  = active_q;

endmodule

// File: tb/tb_uart_rx_parity.sv
// Directed bench for uart_rx_parity at 8 clocks per bit with even parity.
module tb_uart_rx_parity;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       ready;
  logic       clr_ov;
  logic       valid;
  logic [7:0] rx_byte;
  logic       perr;
  logic       ferr;
  logic       overrun;
  logic       active;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [9:0] got_q [$];

  always #5 clk = ~clk;

  uart_rx_parity #(
    .CLKS_PER_BIT (CPB),
    .PARITY_EN    (1'b1),
    .FIFO_DEPTH   (4)
  ) dut (
    .i_Clock       (clk),
    .i_Rst_n       (rst_n),
    .i_Rx_Serial   (rx),
    .i_Rx_Ready    (ready),
    .i_Clr_Overrun (clr_ov),
    .o_Rx_Valid    (valid),
    .o_Rx_Byte     (rx_byte),
    .o_Parity_Err  (perr),
    .o_Frame_Err   (ferr),
    .o_Overrun     (overrun),
    .o_Rx_Active   (active)
  );

  // Record every entry the consumer takes: {frame_err, parity_err, byte}.
  always begin
    @(negedge clk);
    #1;
    if (valid === 1'b1 && ready === 1'b1) got_q.push_back({ferr, perr, rx_byte});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one frame starting at a falling clock edge; returns one cycle
  // after the stop bit ends, which is the first cycle the entry can show.
  task automatic drive_frame(input logic [7:0] data, input logic par,
                             input logic stop_bit, input bit chk_timing);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (CPB) @(negedge clk);
    end
    rx = par;
    repeat (CPB) @(negedge clk);
    rx = stop_bit;
    repeat (CPB - 1) @(negedge clk);
    if (chk_timing) check("valid_before_cleanup", valid, 1'b0);
    @(negedge clk);
    if (chk_timing) check("valid_after_cleanup", valid, 1'b1);
  endtask

  logic [7:0] ov_byte [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
  logic       ov_par  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst_n  = 1'b0;
    rx     = 1'b1;
    ready  = 1'b1;
    clr_ov = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_valid",   valid,   1'b0);
    check("rst_byte",    rx_byte, 8'h00);
    check("rst_perr",    perr,    1'b0);
    check("rst_ferr",    ferr,    1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_active",  active,  1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Clean frame 0xA5 (four ones, parity 0), with push timing.
    got_q.delete();
    drive_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("a5_count", got_q.size(), 1);
    check("a5_entry", got_q[0], {2'b00, 8'hA5});

    // 0x01 with parity 0 is odd overall: parity error.
    got_q.delete();
    drive_frame(8'h01, 1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("perr_count", got_q.size(), 1);
    check("perr_entry", got_q[0], {2'b01, 8'h01});

    // Stop bit low and line held low: frame error, no new frame decoded.
    got_q.delete();
    drive_frame(8'h55, 1'b0, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    check("break_active_held", active, 1'b1);
    check("break_no_push_yet", valid,  1'b0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("break_count",  got_q.size(), 1);
    check("break_entry",  got_q[0], {2'b10, 8'h55});
    check("break_active_done", active, 1'b0);

    // Two-cycle low glitch on an idle line.
    got_q.delete();
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_active_rise", active, 1'b1);
    repeat (10) @(negedge clk);
    check("glitch_active_fall", active, 1'b0);
    check("glitch_no_push",     got_q.size(), 0);
    check("glitch_no_valid",    valid, 1'b0);

    // Overrun: five frames into a four-deep FIFO with nothing consumed.
    got_q.delete();
    ready = 1'b0;
    for (int f = 0; f < 5; f++) begin
      drive_frame(ov_byte[f], ov_par[f], 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      if (f == 3) check("ov_full_no_overrun", overrun, 1'b0);
    end
    check("ov_overrun_set", overrun, 1'b1);
    check("ov_head_valid",  valid,   1'b1);
    check("ov_head_stable", rx_byte, 8'h10);
    clr_ov = 1'b1;
    @(negedge clk);
    clr_ov = 1'b0;
    @(negedge clk);
    check("ov_cleared", overrun, 1'b0);
    ready = 1'b1;
    repeat (10) @(negedge clk);
    check("ov_drain_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ov_entry%0d", i), got_q[i], {2'b00, ov_byte[i]});
    end
    check("ov_drained", valid, 1'b0);

    // Reset in the middle of data bit 3 of 0xC8, then a clean 0x3C.
    got_q.delete();
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_active_before", active, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_active_in_rst", active, 1'b0);
    check("midrst_valid_in_rst",  valid,  1'b0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    drive_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check("midrst_count", got_q.size(), 1);
    check("midrst_entry", got_q[0], {2'b00, 8'h3C});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_parity.md
UART_RX_PARITY -- requirements
Module: uart_rx_parity

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87, sets clocks per serial bit period; the legal minimum is 4.
REQ-002 Parameter PARITY_EN, default 1, selects the frame format: 1 = start, 8 data, even parity, stop; 0 = no parity bit.
REQ-003 Parameter FIFO_DEPTH, default 4, sets the number of received-byte entries; it SHALL be a power of two and at least 2.
REQ-004 i_Clock  in  1  single system clock; all logic is on its rising edge.
REQ-005 i_Rst_n  in  1  asynchronous active-low reset.
REQ-006 i_Rx_Serial  in  1  asynchronous serial line; it idles high.
REQ-007 i_Rx_Ready  in  1  consumer accepts the head FIFO entry.
REQ-008 i_Clr_Overrun  in  1  single-cycle pulse that clears o_Overrun.
REQ-009 o_Rx_Valid  out  1  the FIFO is non-empty and the head entry is presented.
REQ-010 o_Rx_Byte  out  8  data byte of the head entry.
REQ-011 o_Parity_Err  out  1  the head entry's parity check failed; it is always 0 when PARITY_EN=0.
REQ-012 o_Frame_Err  out  1  the head entry's stop bit was sampled as 0.
REQ-013 o_Overrun  out  1  sticky flag: a completed frame was dropped because the FIFO was full.
REQ-014 o_Rx_Active  out  1  a frame is in progress.

Function
REQ-015 i_Rx_Serial SHALL pass through a 2-flop synchronizer reset to 1; every line reference below is to the synchronized signal.
REQ-016 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP, CLEANUP and WAIT_HIGH.
REQ-017 IDLE: when the line is 0, clear the bit counter and bit index and go to START.
REQ-018 START: count to (CLKS_PER_BIT-1)/2; at that point, if the line is 0, clear the counter and go to DATA; if the line is 1, treat it as a glitch and return to IDLE with no FIFO push.
REQ-019 DATA: sample the line when the counter reaches CLKS_PER_BIT-1, which is mid-bit; store samples LSB first into bit index 0..7; after index 7, go to PARITY if PARITY_EN=1, otherwise go to STOP.
REQ-020 PARITY: sample the parity bit mid-bit; the parity error is set when the XOR of the 8 data bits and the parity bit is 1 (even parity).
REQ-021 STOP: sample the stop bit mid-bit; if it is 1, go to CLEANUP; if it is 0, set the frame error and go to WAIT_HIGH.
REQ-022 WAIT_HIGH: remain until the line is 1, then go to CLEANUP; this prevents a break condition from being decoded as a new start bit.
REQ-023 CLEANUP: lasts one cycle; it pushes {frame_err, parity_err, byte} into the FIFO, then goes to IDLE.
REQ-024 The bit counter width SHALL be $clog2(CLKS_PER_BIT) and the counter SHALL wrap to 0 at every bit boundary.
REQ-025 o_Rx_Active SHALL be registered: it rises the cycle after START is entered and falls the cycle after CLEANUP is exited, and it is also cleared on a glitch return from START.
REQ-026 The FIFO SHALL be show-ahead: o_Rx_Valid and the head-entry outputs are valid in the cycle after the CLEANUP push.
REQ-027 A pop SHALL occur when o_Rx_Valid and i_Rx_Ready are both 1; the outputs SHALL remain stable while o_Rx_Valid=1 and i_Rx_Ready=0.
REQ-028 If a push and a pop occur in the same cycle on a full FIFO, both are accepted and no overrun is raised.
REQ-029 A push on a full FIFO with no pop SHALL drop the new entry and set o_Overrun.
REQ-030 o_Overrun SHALL stay set until i_Clr_Overrun; if a set and a clear occur in the same cycle, the set wins.
REQ-031 The FIFO read and write pointers SHALL be $clog2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full/empty is distinguished by the MSB of the pointers.

Reset
REQ-032 While i_Rst_n=0, regardless of clock, the FSM SHALL be in IDLE with the counter and index at 0, the synchronizer at 1, and the FIFO empty.
REQ-033 The output reset values SHALL be: o_Rx_Valid=0, o_Rx_Byte=0, o_Parity_Err=0, o_Frame_Err=0, o_Overrun=0, o_Rx_Active=0.
REQ-034 A reset asserted mid-frame SHALL discard the partial frame; after release, the block resynchronizes only on the next high-to-low line transition.

Structure
REQ-035 A shared package uart_pkg SHALL hold the FSM state encoding, DATA_BITS=8, and the FIFO entry width of 10 bits.
REQ-036 The FIFO SHALL be a separate sub-module, uart_rx_fifo, parameterized by width and depth, with the same clock and reset.

Verification
REQ-037 CLKS_PER_BIT=8, PARITY_EN=1, frame with byte 0xA5 and parity 0 -> a single entry 0xA5 with Parity_Err=0 and Frame_Err=0, o_Rx_Valid rising the cycle after CLEANUP.
REQ-038 Frame with byte 0x01 and parity 0 -> entry 0x01 with Parity_Err=1.
REQ-039 Stop bit forced to 0 and the line held low for 30 cycles -> entry with Frame_Err=1, the FSM remaining in WAIT_HIGH until the line rises, and no second frame decoded.
REQ-040 A 2-cycle low glitch on an idle line -> no push and o_Rx_Active returning to 0.
REQ-041 With i_Rx_Ready=0, send 5 frames of bytes 0x10 through 0x14 -> o_Overrun=1 and a FIFO holding 0x10 through 0x13; then i_Clr_Overrun -> o_Overrun=0.
REQ-042 Assert i_Rst_n=0 during data bit 3, release it, then send 0x3C -> only the entry 0x3C is output.
